cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 for the pipelined MIPS core: the CPU-side consumer of peripheral interrupt lines such as the timer's IRQ. It samples hardware interrupt requests, arbitrates them against synchronous exceptions reported by the M stage, and holds the SR/Cause/EPC/PRId registers. It serves mfc0/mtc0/eret and drives the pipeline flush/redirect request. It sits beside the M stage and its bus bridge.

## Interface
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address (exported for the PC mux)
- PRID_VAL, 32'h2021_0001, read-only PRId contents
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pc  in  32  macro-PC of the M-stage slot; bubbles carry their successor's PC, so this is always valid
- bd  in  1  M-stage instruction sits in a branch delay slot
- exc_code  in  5  synchronous exception code from M; 0 = none
- hw_int  in  6  level interrupt lines; [2] = timer IRQ, [3] = second timer, [4] = external
- sel  in  5  CP0 register number for mfc0/mtc0
- we  in  1  mtc0 in M
- wdata  in  32  mtc0 data
- eret  in  1  eret in M
- rdata  out  32  mfc0 data
- req  out  1  take exception/interrupt now: flush F..M, redirect PC to HANDLER_PC
- epc_out  out  32  current EPC, used as the eret target

## Operation
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, low two bits forced 0.
  - PRId(15): constant.
- int_req = |(hw_int & IM) & IE & ~EXL
- exc_req = (exc_code != 0) & ~EXL; exceptions ignore IE.
- req = int_req | exc_req. Interrupt has priority over exception in the same cycle.
- On req (clock edge): EXL←1, ExcCode←(int_req ? 0 : exc_code), BD←bd, EPC←(bd ? pc−4 : pc) & ~3.
- Cause.IP←hw_int every cycle, independent of mask and EXL.
- Two-state view, driven by EXL:
  - NORMAL→HANDLER on req.
  - HANDLER→NORMAL on eret.
  - req cannot fire in HANDLER.
- mtc0: writes SR (IM/EXL/IE only) or EPC; writes to Cause and PRId are ignored. mtc0 is suppressed in any cycle with req=1, because the instruction is being flushed.
- eret in HANDLER: EXL←0. eret with EXL=0 also clears EXL (no-op); no other effect.
- rdata = register selected by sel, combinational from register state (pre-update values). Unmapped sel → 0.

## Timing
- req is combinational from the current inputs and registers, valid in the same cycle. Register updates land at the following edge.
- Reset: SR=0, Cause=0, EPC=0, and req is forced 0 during the reset cycle. rdata then reflects the zeroed registers; epc_out=0.
- IP reflects hw_int with one cycle of latency. The interrupt decision uses the live hw_int (zero latency).
- mtc0 SR with IE 0→1 and a pending hw_int: req asserts the next cycle, not in the write cycle.
- eret and hw_int in the same cycle: no req. EXL clears; req asserts the next cycle if the interrupt is still enabled and pending.
- epc_out shows the post-edge EPC. mtc0 EPC followed by eret in the next cycle sees the new value, so the pipeline needs no bypass beyond one cycle.
- Reset asserted while EXL=1 returns the block to NORMAL with all registers cleared.

## Structure
- Shared package cp0_pkg holds:
  - register numbers 12–15
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12
  - HANDLER_PC and PRID_VAL
  - SR/Cause bit-position constants
- Single module; no sub-module is warranted. Priority logic and register file are about 150 lines.

## Test plan
- Reset, then read sel 12/13/14/15 → 0, 0, 0, PRID_VAL; req=0 during reset even with exc_code=10.
- SR=0x0000_0401 (IM[10], IE), hw_int=6'b000001, pc=0x3008, bd=0 → req=1 that cycle; next cycle Cause.ExcCode=0, EPC=0x3008, SR.EXL=1.
- exc_code=12, bd=1, pc=0x3010, SR=0 → req=1; EPC=0x300C, Cause[31]=1, ExcCode=12.
- EXL=1, hw_int active and exc_code=4 → req=0; then eret → EXL=0, and req=1 in the following cycle.
- mtc0 EPC=0x3003 with no req → EPC reads 0x3000; same write coinciding with req → EPC gets the exception PC, not wdata.
- Interrupt and exc_code=5 in the same cycle with the interrupt enabled → ExcCode=0 (interrupt wins).

Source files
------------

// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions: register numbers, exception codes,
// constant values and register bit positions.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL   = 32'h2021_0001;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } cp0_state_t;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0: interrupt/exception arbitration, SR/Cause/EPC/PRId,
// mfc0/mtc0/eret service and pipeline flush request.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc_out
);

  cp0_state_t state;
  cp0_state_t state_nxt;

  logic [5:0]  im;
  logic        ie;
  logic        bd_q;
  logic [5:0]  ip;
  logic [4:0]  exc_q;
  logic [31:0] epc;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_nxt;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign exl = (state == HANDLER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // An eret after an SR write in the same slot still leaves EXL clear.
  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      req:   state_nxt = HANDLER;
      eret:  state_nxt = NORMAL;
      sr_wr: state_nxt = wdata[SR_EXL] ? HANDLER : NORMAL;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    int_req = 1'b0;
    exc_req = 1'b0;
    req     = 1'b0;
    if (!reset) begin
      int_req = (|(hw_int & im)) & ie & ~exl;
      exc_req = (exc_code != EXC_INT) & ~exl;
      req     = int_req | exc_req;
    end
  end

  assign sr_wr  = we & ~req & (sel == REG_SR);
  assign epc_wr = we & ~req & (sel == REG_EPC);

  assign epc_nxt = bd ? (pc - 32'd4) : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      im    <= '0;
      ie    <= 1'b0;
      bd_q  <= 1'b0;
      ip    <= '0;
      exc_q <= '0;
      epc   <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exc_q <= int_req ? EXC_INT : exc_code;
        bd_q  <= bd;
        epc   <= {epc_nxt[31:2], 2'b00};
      end else begin
        if (sr_wr) begin
          im <= wdata[SR_IM_LO +: 6];
          ie <= wdata[SR_IE];
        end
        if (epc_wr) begin
          epc <= {wdata[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    sr_word                     = '0;
    sr_word[SR_IM_LO +: 6]      = im;
    sr_word[SR_EXL]             = exl;
    sr_word[SR_IE]              = ie;
    cause_word                  = '0;
    cause_word[CAUSE_BD]        = bd_q;
    cause_word[CAUSE_IP_LO +: 6] = ip;
    cause_word[CAUSE_EXC_LO +: 5] = exc_q;
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      REG_SR:    rdata = sr_word;
      REG_CAUSE: rdata = cause_word;
      REG_EPC:   rdata = epc;
      REG_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios then random traffic,
// all checked against an architectural model of the CP0 registers.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic [4:0]  sel;
  logic        we;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] epc_out;

  cp0_unit dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hw_int   (hw_int),
    .sel      (sel),
    .we       (we),
    .wdata    (wdata),
    .eret     (eret),
    .rdata    (rdata),
    .req      (req),
    .epc_out  (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // architectural state of the reference model
  int unsigned m_im, m_ie, m_exl, m_bd, m_ip, m_exc, m_epc;

  function automatic int unsigned read_reg(input int unsigned s);
    case (s)
      12: return (m_im << 10) + (m_exl << 1) + m_ie;
      13: return (m_bd << 31) + (m_ip << 10) + (m_exc << 2);
      14: return m_epc;
      15: return 32'h2021_0001;
      default: return 0;
    endcase
  endfunction

  task automatic step(
    input bit          r   = 0,
    input logic [4:0]  s   = 5'd12,
    input logic [5:0]  h   = 6'd0,
    input logic [4:0]  ec  = 5'd0,
    input bit          w   = 0,
    input logic [31:0] wd  = 32'd0,
    input bit          er  = 0,
    input logic [31:0] p   = 32'h3000,
    input bit          b   = 0,
    input bit          crd = 1
  );
    exp_t e;
    bit pend, irq, xrq;
    reset = r; sel = s; hw_int = h; exc_code = ec;
    we = w; wdata = wd; eret = er; pc = p; bd = b;
    pend = ((h & m_im) != 0);
    irq = !r && pend && m_ie == 1 && m_exl == 0;
    xrq = !r && ec != 0 && m_exl == 0;
    e.req = irq || xrq;
    e.rdata = read_reg(s);
    e.epc = m_epc;
    e.chk_rd = crd;
    e.cyc = cyc;
    exp_q.push_back(e);
    if (r) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0;
      m_ip = 0; m_exc = 0; m_epc = 0;
    end else begin
      m_ip = h;
      if (irq || xrq) begin
        m_exl = 1;
        m_exc = irq ? 0 : ec;
        m_bd = b;
        m_epc = ((b ? p - 4 : p) / 4) * 4;
      end else begin
        if (w && s == 12) begin
          m_im = (wd >> 10) % 64;
          m_exl = (wd >> 1) % 2;
          m_ie = wd % 2;
        end
        if (w && s == 14) m_epc = (wd / 4) * 4;
        if (er) m_exl = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (req !== e.req) begin
        errors++;
        $display("FAIL req cyc=%0d got=%b exp=%b", e.cyc, req, e.req);
      end
      if (e.chk_rd) begin
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata cyc=%0d sel=%0d got=%h exp=%h",
                   e.cyc, sel, rdata, e.rdata);
        end
        checks++;
        if (epc_out !== e.epc) begin
          errors++;
          $display("FAIL epc_out cyc=%0d got=%h exp=%h",
                   e.cyc, epc_out, e.epc);
        end
      end
    end
  end

  function automatic logic [4:0] rand_exc();
    int unsigned k;
    k = $urandom_range(0, 15);
    case (k)
      0: return 5'd4;
      1: return 5'd5;
      2: return 5'd10;
      3: return 5'd12;
      4: return 5'($urandom);
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] rand_sel();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1: return 5'd12;
      2, 3: return 5'd13;
      4, 5: return 5'd14;
      6:    return 5'd15;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1; pc = 0; bd = 0; exc_code = 0; hw_int = 0;
    sel = 0; we = 0; wdata = 0; eret = 0;
    @(posedge clk);
    #1;
    // reset: req held low even with a pending RI exception
    step(.r(1), .ec(10), .s(12), .crd(0));
    step(.r(1), .ec(10), .s(13));
    step(.s(12));
    step(.s(13));
    step(.s(14));
    step(.s(15));
    // enable IM[10]/IE with the line already high; req follows next cycle
    step(.w(1), .s(12), .wd(32'h0000_0401), .h(6'b000001));
    step(.h(6'b000001), .p(32'h3008));
    step(.s(13));
    step(.s(14));
    step(.s(12), .h(6'b000001));
    step(.er(1), .s(12));
    step(.w(1), .s(12), .wd(32'h0));
    // overflow in a delay slot
    step(.ec(12), .b(1), .p(32'h3010));
    step(.s(14));
    step(.s(13));
    // in handler: interrupt plus AdEL ignored, then eret with line high
    step(.w(1), .s(12), .wd(32'h0000_0403));
    step(.h(6'b000001), .ec(4), .s(13));
    step(.er(1), .h(6'b000001), .s(12));
    step(.h(6'b000001), .p(32'h3040), .s(12));
    step(.s(14));
    step(.er(1));
    // EPC write masking and write suppressed by a coincident exception
    step(.w(1), .s(12), .wd(32'h0));
    step(.w(1), .s(14), .wd(32'h0000_3003));
    step(.s(14));
    step(.w(1), .s(14), .wd(32'h0000_5557), .ec(10), .p(32'h3020));
    step(.s(14));
    step(.er(1), .s(14));
    // interrupt beats AdES in the same cycle
    step(.w(1), .s(12), .wd(32'h0000_0401));
    step(.h(6'b000001), .ec(5), .p(32'h3030));
    step(.s(13));
    step(.s(12));
    // reset from handler state
    step(.r(1), .s(12));
    step(.s(12));
    step(.s(13));
    step(.s(14));
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r, w, er;
      logic [31:0] wd;
      r  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 4) == 0);
      er = !w && ($urandom_range(0, 7) == 0);
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) wd[0] = 1'b1;
      step(.r(r), .s(rand_sel()),
           .h(6'($urandom) & 6'($urandom)),
           .ec(rand_exc()), .w(w), .wd(wd), .er(er),
           .p($urandom), .b(1'($urandom)));
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
